// File: rtl/cc3_viterbi_decoder.sv
// Hard-decision Viterbi decoder for the K=3 rate-1/2 code: 4-state ACS, register-exchange
// survivors of TB_DEPTH bits, and a flag raised whenever a symbol lifts the best path metric.
module cc3_viterbi_decoder #(
  parameter logic [2:0] G0       = 3'b111,
  parameter logic [2:0] G1       = 3'b101,
  parameter int         TB_DEPTH = 16,
  parameter int         PM_W     = 5
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  input  logic            sym1,
  input  logic            sym2,
  output logic            dec_valid,
  output logic            dec_bit,
  output logic [PM_W-1:0] best_metric,
  output logic            err_flag
);

  localparam int CNT_W = $clog2(TB_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TB_DEPTH - 1);

  logic [3:0][PM_W-1:0]     pm_q, pm_d, pm_acs, cand0, cand1;
  logic [3:0][TB_DEPTH-1:0] path_q, path_d, path_acs;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [PM_W-1:0]          best_q, best_d, best_raw;
  logic [1:0]               best_idx;
  logic                     norm;
  logic                     dec_valid_q, dec_valid_d;
  logic                     dec_bit_q, dec_bit_d;
  logic                     err_flag_q, err_flag_d;

  // Hamming distance between the received pair and the branch label for register {u,a,b}.
  function automatic logic [1:0] bmetric(input logic [2:0] r, input logic s1, input logic s2);
    logic e1, e2;
    e1 = s1 ^ (^(G0 & r));
    e2 = s2 ^ (^(G1 & r));
    return {1'b0, e1} + {1'b0, e2};
  endfunction

  // State n = {u,a}; its predecessors are {a,0} (index 2a) and {a,1} (index 2a+1).
  always_comb begin
    cand0    = '0;
    cand1    = '0;
    pm_acs   = '0;
    path_acs = '0;
    for (int n = 0; n < 4; n++) begin
      cand0[n] = pm_q[2*(n%2)]   + PM_W'(bmetric({n[1], n[0], 1'b0}, sym1, sym2));
      cand1[n] = pm_q[2*(n%2)+1] + PM_W'(bmetric({n[1], n[0], 1'b1}, sym1, sym2));
      if (cand1[n] < cand0[n]) begin
        pm_acs[n]   = cand1[n];
        path_acs[n] = {path_q[2*(n%2)+1][TB_DEPTH-2:0], n[1]};
      end else begin
        pm_acs[n]   = cand0[n];
        path_acs[n] = {path_q[2*(n%2)][TB_DEPTH-2:0], n[1]};
      end
    end
    best_raw = pm_acs[0];
    best_idx = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (pm_acs[i] < best_raw) begin
        best_raw = pm_acs[i];
        best_idx = 2'(i);
      end
    end
    norm = pm_acs[0][PM_W-1] & pm_acs[1][PM_W-1] & pm_acs[2][PM_W-1] & pm_acs[3][PM_W-1];
  end

  always_comb begin
    pm_d        = pm_q;
    path_d      = path_q;
    cnt_d       = cnt_q;
    best_d      = best_q;
    dec_valid_d = 1'b0;
    err_flag_d  = 1'b0;
    dec_bit_d   = dec_bit_q;
    if (in_valid) begin
      for (int i = 0; i < 4; i++)
        pm_d[i] = norm ? {1'b0, pm_acs[i][PM_W-2:0]} : pm_acs[i];
      path_d      = path_acs;
      best_d      = norm ? {1'b0, best_raw[PM_W-2:0]} : best_raw;
      err_flag_d  = best_raw > best_q;
      dec_valid_d = cnt_q == CNT_MAX;
      dec_bit_d   = dec_valid_d & path_acs[best_idx][TB_DEPTH-1];
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pm_q        <= {PM_W'(4), PM_W'(4), PM_W'(4), PM_W'(0)};
      path_q      <= '0;
      cnt_q       <= '0;
      best_q      <= '0;
      dec_valid_q <= 1'b0;
      dec_bit_q   <= 1'b0;
      err_flag_q  <= 1'b0;
    end else begin
      pm_q        <= pm_d;
      path_q      <= path_d;
      cnt_q       <= cnt_d;
      best_q      <= best_d;
      dec_valid_q <= dec_valid_d;
      dec_bit_q   <= dec_bit_d;
      err_flag_q  <= err_flag_d;
    end
  end

  assign dec_valid   = dec_valid_q;
  assign dec_bit     = dec_bit_q;
  assign best_metric = best_q;
  assign err_flag    = err_flag_q;

endmodule

// File: tb/tb_cc3_viterbi_decoder.sv
// Randomized scoreboard bench: an encoder/channel model predicts the decoded bits, the best
// metric (error count modulo half the metric range) and err_flag for every accepted symbol.
module tb_cc3_viterbi_decoder;
  localparam int TB_DEPTH = 16;
  localparam int PM_W     = 5;
  localparam int LAT      = TB_DEPTH - 1;

  logic            clock = 1'b0, reset_n = 1'b0, in_valid = 1'b0, sym1 = 1'b0, sym2 = 1'b0;
  logic            dec_valid, dec_bit, err_flag;
  logic [PM_W-1:0] best_metric;

  cc3_viterbi_decoder #(.G0(3'b111), .G1(3'b101), .TB_DEPTH(TB_DEPTH), .PM_W(PM_W)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .sym1(sym1), .sym2(sym2),
    .dec_valid(dec_valid), .dec_bit(dec_bit), .best_metric(best_metric), .err_flag(err_flag)
  );

  always #5 clock = ~clock;

  typedef struct { bit dv; bit db; int best; bit err; } exp_t;
  exp_t sb[$];
  bit   hist[$];
  int   errs = 0, n_chk = 0, n_fail = 0, last_best = 0;
  bit   last_db = 1'b0, acc = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expectation per accepted symbol; idle cycles must show held/quiet outputs.
  always @(posedge clock) acc <= in_valid && reset_n;

  always @(negedge clock) begin
    exp_t e;
    if (acc) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("dec_valid", int'(dec_valid), int'(e.dv));
        chk("dec_bit", int'(dec_bit), int'(e.db));
        chk("best_metric", int'(best_metric), e.best);
        chk("err_flag", int'(err_flag), int'(e.err));
        last_best = e.best;
        last_db   = e.db;
      end
    end else begin
      chk("idle_dec_valid", int'(dec_valid), 0);
      chk("idle_err_flag", int'(err_flag), 0);
      chk("idle_best_hold", int'(best_metric), last_best);
      chk("idle_bit_hold", int'(dec_bit), int'(last_db));
    end
  end

  // Encode u from the input history, optionally flip one code bit, record expectation, drive.
  task automatic send(input bit u, input bit flip);
    exp_t e;
    int   k = hist.size();
    bit   p1 = (k >= 1) ? hist[k-1] : 1'b0;
    bit   p2 = (k >= 2) ? hist[k-2] : 1'b0;
    bit   c1 = u ^ p1 ^ p2;
    bit   c2 = u ^ p2;
    if (flip) begin
      if ($urandom_range(1, 0) == 1) c1 = ~c1;
      else                           c2 = ~c2;
      errs++;
    end
    hist.push_back(u);
    e.dv   = k >= LAT;
    e.db   = e.dv ? hist[k-LAT] : 1'b0;
    e.best = errs % (1 << (PM_W - 1));
    e.err  = flip;
    sb.push_back(e);
    in_valid = 1'b1;
    sym1     = c1;
    sym2     = c2;
    @(posedge clock); #1;
    in_valid = 1'b0;
    sym1     = 1'($urandom);
    sym2     = 1'($urandom);
  endtask

  // n data bits followed by LAT zero tail symbols; stop >= 0 aborts after that symbol index.
  task automatic run(input int n, input bit zero, input int fp, input bit toggle,
                     input int stop, input bit pat);
    bit lead[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < n + LAT; i++) begin
      bit u;
      if (i >= n || zero) u = 1'b0;
      else if (pat && i < 4) u = lead[i];
      else u = 1'($urandom);
      send(u, fp > 0 && (i % fp) == fp - 1);
      if (toggle) begin @(posedge clock); #1; end
      if (i == stop) return;
    end
  endtask

  task automatic do_reset();
    @(negedge clock); #2;
    reset_n  = 1'b0;
    in_valid = 1'b1;
    #1;
    chk("rst_dec_valid", int'(dec_valid), 0);
    chk("rst_dec_bit", int'(dec_bit), 0);
    chk("rst_best_metric", int'(best_metric), 0);
    chk("rst_err_flag", int'(err_flag), 0);
    chk("sb_drained", sb.size(), 0);
    sb.delete();
    hist.delete();
    errs      = 0;
    last_best = 0;
    last_db   = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    @(posedge clock); #1;
  endtask

  initial begin
    #1;
    chk("por_dec_valid", int'(dec_valid), 0);
    chk("por_best_metric", int'(best_metric), 0);
    do_reset();
    run(25, 1'b1, 0, 1'b0, -1, 1'b0);    // 40 all-zero symbols
    do_reset();
    run(200, 1'b0, 0, 1'b0, -1, 1'b0);   // clean random stream
    do_reset();
    run(200, 1'b0, 10, 1'b0, -1, 1'b0);  // one flipped code bit per 10 symbols
    do_reset();
    run(985, 1'b0, 6, 1'b0, -1, 1'b0);   // heavy noise, metrics must normalize
    do_reset();
    run(100, 1'b0, 0, 1'b1, -1, 1'b0);   // in_valid alternating
    do_reset();
    run(200, 1'b0, 0, 1'b0, 50, 1'b0);   // abort after symbol 50 ...
    do_reset();
    run(60, 1'b0, 0, 1'b0, -1, 1'b1);    // ... then a fresh 1,0,1,1... stream
    repeat (3) @(posedge clock);
    #1;
    chk("sb_final_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
